// File: rtl/vn_narrow_pack.sv
// Narrows 32-bit signed PE results (optional rounding shift, truncate or saturate) and packs them into 32-bit words.
// Latency: one cycle from acceptance of the word-completing element to out_valid.
// Backpressure: single output register; in_ready drops while a finished word is held and out_ready is low.
module vn_narrow_pack #(
  parameter int W          = 32,
  parameter bit SAT_STICKY = 1'b1
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  input  logic [1:0]     vsew,
  input  logic [4:0]     shamt,
  input  logic           round_en,
  input  logic           sat_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [W/8-1:0] out_be,
  output logic           vxsat,
  input  logic           clear_sat
);

  localparam int NB = W / 8;

  // Word-building state: lane counter, element width latched at lane 0, partial data and byte enables.
  logic [1:0]    cnt;
  logic [1:0]    word_sew;
  logic [W-1:0]  pack_data;
  logic [NB-1:0] pack_be;

  // Per-element datapath signals.
  logic            accept;
  logic            complete;
  logic [1:0]      eff_sew;
  logic [1:0]      last_cnt;
  logic [5:0]      sew_bits;
  logic [4:0]      lane_off;
  logic [W:0]      rnd;
  logic signed [W:0] r;
  logic signed [W:0] s;
  logic signed [W:0] sat_max;
  logic signed [W:0] sat_min;
  logic [W-1:0]    val;
  logic [W-1:0]    mask;
  logic [W-1:0]    placed;
  logic [NB-1:0]   elem_be;
  logic            sat_hit;

  // The output register frees up in the same cycle it drains, so filling never stalls while the consumer is ready.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Element width in force for this element: sampled live on lane 0, otherwise the value latched for the word.
  always_comb begin
    eff_sew = word_sew;
    if (cnt == 2'd0) begin
      eff_sew = vsew[1] ? 2'd2 : vsew;
    end
  end

  // Lane geometry for the current element width.
  always_comb begin
    sew_bits = 6'd32;
    last_cnt = 2'd0;
    lane_off = 5'd0;
    elem_be  = {NB{1'b1}};
    case (eff_sew)
      2'd0: begin
        sew_bits = 6'd8;
        last_cnt = 2'd3;
        lane_off = {cnt, 3'b000};
        elem_be  = NB'(1) << cnt;
      end
      2'd1: begin
        sew_bits = 6'd16;
        last_cnt = 2'd1;
        lane_off = {cnt[0], 4'b0000};
        elem_be  = NB'(3) << {cnt[0], 1'b0};
      end
      default: begin
        sew_bits = 6'd32;
        last_cnt = 2'd0;
        lane_off = 5'd0;
        elem_be  = {NB{1'b1}};
      end
    endcase
  end

  // Rounding shift in W+1 bits so the rounding increment cannot wrap, then clip or truncate to the element width.
  always_comb begin
    rnd = '0;
    if (round_en && (shamt != 5'd0)) begin
      rnd = (W+1)'(1) << (shamt - 5'd1);
    end
    r       = $signed({in_data[W-1], in_data}) + $signed(rnd);
    s       = r >>> shamt;
    sat_max = $signed(((W+1)'(1) << (sew_bits - 6'd1)) - (W+1)'(1));
    sat_min = ~sat_max;
    mask    = (W'(1) << sew_bits) - W'(1);
    val     = s[W-1:0];
    sat_hit = 1'b0;
    if (sat_en) begin
      if (s > sat_max) begin
        val     = sat_max[W-1:0];
        sat_hit = 1'b1;
      end else if (s < sat_min) begin
        val     = sat_min[W-1:0];
        sat_hit = 1'b1;
      end
    end
    placed = (val & mask) << lane_off;
  end

  assign complete = (cnt == last_cnt) || in_last;

  // Packing and output register: a completing element moves the word into the output register next cycle.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt       <= 2'd0;
      word_sew  <= 2'd0;
      pack_data <= '0;
      pack_be   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_be    <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (cnt == 2'd0) begin
          word_sew <= eff_sew;
        end
        if (complete) begin
          out_valid <= 1'b1;
          out_data  <= pack_data | placed;
          out_be    <= pack_be | elem_be;
          cnt       <= 2'd0;
          pack_data <= '0;
          pack_be   <= '0;
        end else begin
          pack_data <= pack_data | placed;
          pack_be   <= pack_be | elem_be;
          cnt       <= cnt + 2'd1;
        end
      end
    end
  end

  // Saturation flag: a saturating element always beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      vxsat <= 1'b0;
    end else if (SAT_STICKY) begin
      if (accept && sat_hit) begin
        vxsat <= 1'b1;
      end else if (clear_sat) begin
        vxsat <= 1'b0;
      end
    end else begin
      if (accept) begin
        vxsat <= sat_hit;
      end else if (clear_sat) begin
        vxsat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vn_narrow_pack.sv
// Bench for vn_narrow_pack: scoreboarded packed words plus per-scenario handshake and flag checks.
module tb_vn_narrow_pack;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  vsew;
  logic [4:0]  shamt;
  logic        round_en;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        vxsat;
  logic        clear_sat;

  int          vectors = 0;
  int          miscompares = 0;
  bit          done = 1'b0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  vn_narrow_pack #(.W(32), .SAT_STICKY(1'b1)) dut (
    .clk(clk), .n_reset(n_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .vsew(vsew), .shamt(shamt), .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_be(out_be),
    .vxsat(vxsat), .clear_sat(clear_sat)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference narrowing for an 8-bit saturating element.
  function automatic logic [7:0] model8(input int d, input int sh, input bit rnd, output bit sat);
    longint r;
    r = d;
    if (rnd && sh != 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    return r[7:0];
  endfunction

  // Output side: every word handed over is checked against the front of the scoreboard.
  task automatic monitor();
    logic [35:0] e;
    while (!done) begin
      @(negedge clk);
      if (n_reset && out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word: got data %h be %b, none expected", out_data, out_be);
        end else begin
          e = exp_q.pop_front();
          if ({out_be, out_data} !== e) begin
            miscompares++;
            $display("FAIL word: got data %h be %b, expected data %h be %b", out_data, out_be, e[31:0], e[35:32]);
          end
        end
      end
    end
  endtask

  // Presents one element and returns 1 time unit after the edge on which it was accepted.
  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin n++; @(negedge clk); end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready %b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d words outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 32'h0) begin miscompares++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    vectors++; if (out_be !== 4'h0) begin miscompares++; $display("FAIL rst_out_be: got %b expected 0000", out_be); end
    vectors++; if (vxsat !== 1'b0) begin miscompares++; $display("FAIL rst_vxsat: got %b expected 0", vxsat); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_reset = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_sat8();
    vsew = 2'd0; sat_en = 1'b1; shamt = 5'd0; round_en = 1'b0;
    exp_q.push_back({4'b1111, 32'h807FFD05});
    send(32'd5, 1'b0);
    send(32'hFFFFFFFD, 1'b0);
    vectors++; if (vxsat !== 1'b0) begin miscompares++; $display("FAIL sat8_no_sat_yet: vxsat %b expected 0", vxsat); end
    send(32'd300, 1'b0);
    send(32'hFFFFFF38, 1'b1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sat8_latency: out_valid %b expected 1", out_valid); end
    vectors++; if (vxsat !== 1'b1) begin miscompares++; $display("FAIL sat8_vxsat: got %b expected 1", vxsat); end
    drain();
    clear_sat = 1'b1; @(posedge clk); #1; clear_sat = 1'b0;
    vectors++; if (vxsat !== 1'b0) begin miscompares++; $display("FAIL sat8_clear: vxsat %b expected 0", vxsat); end
  endtask

  task automatic test_round16();
    vsew = 2'd1; shamt = 5'd4; round_en = 1'b1; sat_en = 1'b0;
    exp_q.push_back({4'b1111, 32'h00010002});
    send(32'h18, 1'b0);
    send(32'h17, 1'b0);
    vectors++; if (vxsat !== 1'b0) begin miscompares++; $display("FAIL round16_vxsat: got %b expected 0", vxsat); end
    // Negative rounding shift and plain truncation of a wide value.
    shamt = 5'd1;
    exp_q.push_back({4'b1111, 32'h0003FFFF});
    send(32'hFFFFFFFD, 1'b0);
    send(32'd5, 1'b0);
    shamt = 5'd0; round_en = 1'b0;
    exp_q.push_back({4'b1111, 32'h23452345});
    send(32'h00012345, 1'b0);
    send(32'hFFFF2345, 1'b0);
    drain();
  endtask

  task automatic test_partial();
    vsew = 2'd0; shamt = 5'd0; round_en = 1'b0; sat_en = 1'b0;
    exp_q.push_back({4'b0111, 32'h00030201});
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    exp_q.push_back({4'b0001, 32'h00000044});
    send(32'h44, 1'b1);
    vsew = 2'd1;
    exp_q.push_back({4'b0011, 32'h0000BEEF});
    send(32'h0000BEEF, 1'b1);
    vsew = 2'd3;
    exp_q.push_back({4'b1111, 32'hCAFEF00D});
    send(32'hCAFEF00D, 1'b0);
    // Width change mid-word is ignored until the next word.
    vsew = 2'd0;
    exp_q.push_back({4'b1111, 32'h44332211});
    send(32'h11, 1'b0);
    vsew = 2'd1;
    send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; vsew = 2'd2; sat_en = 1'b0;
    exp_q.push_back({4'b1111, 32'h12345678});
    exp_q.push_back({4'b1111, 32'h0000ABCD});
    send(32'h12345678, 1'b0);
    in_data = 32'h0000ABCD; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      vectors++; if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h/%b expected 12345678/1", i, out_data, out_valid); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 32'h0000ABCD) begin miscompares++; $display("FAIL bp_same_cycle: got %b/%h expected 1/0000abcd", out_valid, out_data); end
    drain();
  endtask

  task automatic test_sticky();
    vsew = 2'd0; sat_en = 1'b1; shamt = 5'd0; round_en = 1'b0;
    exp_q.push_back({4'b0001, 32'h0000007F});
    clear_sat = 1'b1;
    send(32'd1000, 1'b1);
    clear_sat = 1'b0;
    vectors++; if (vxsat !== 1'b1) begin miscompares++; $display("FAIL sticky_set_wins: vxsat %b expected 1", vxsat); end
    @(posedge clk); #1;
    vectors++; if (vxsat !== 1'b1) begin miscompares++; $display("FAIL sticky_hold: vxsat %b expected 1", vxsat); end
    clear_sat = 1'b1; @(posedge clk); #1; clear_sat = 1'b0;
    vectors++; if (vxsat !== 1'b0) begin miscompares++; $display("FAIL sticky_clear: vxsat %b expected 0", vxsat); end
    drain();
  endtask

  task automatic test_reset_midword();
    vsew = 2'd0; sat_en = 1'b0;
    send(32'h01, 1'b0); send(32'h02, 1'b0);
    n_reset = 1'b0; @(posedge clk); #1; n_reset = 1'b1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    exp_q.push_back({4'b1111, 32'h44332211});
    send(32'h11, 1'b0); send(32'h22, 1'b0); send(32'h33, 1'b0); send(32'h44, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    bit          any_sat;
    bit          sat;
    int          d;
    time         t0;
    w = '0; any_sat = 1'b0;
    vsew = 2'd0; sat_en = 1'b1;
    clear_sat = 1'b1; @(posedge clk); #1; clear_sat = 1'b0;
    t0 = $time;
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 4000)) - 2000;
      shamt = 5'($urandom_range(0, 4));
      round_en = 1'($urandom_range(0, 1));
      w[8*(i%4) +: 8] = model8(d, int'(shamt), round_en, sat);
      any_sat = any_sat | sat;
      if (i % 4 == 3) begin exp_q.push_back({4'b1111, w}); w = '0; end
      send(32'(d), 1'b0);
    end
    vectors++; if ($time - t0 != 160) begin miscompares++; $display("FAIL b2b_throughput: took %0t expected 160", $time - t0); end
    vectors++; if (vxsat !== any_sat) begin miscompares++; $display("FAIL b2b_vxsat: got %b expected %b", vxsat, any_sat); end
    drain();
  endtask

  task automatic run_all();
    test_reset();
    test_sat8();
    test_round16();
    test_partial();
    test_backpressure();
    test_sticky();
    test_reset_midword();
    test_back_to_back();
    repeat (2) @(posedge clk);
    done = 1'b1;
  endtask

  initial begin
    n_reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    vsew = 2'd0; shamt = 5'd0; round_en = 1'b0; sat_en = 1'b0;
    out_ready = 1'b0; clear_sat = 1'b0;
    fork
      monitor();
      run_all();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vn_narrow_pack.md
Name: vn_narrow_pack

Overview:
Result-side counterpart to the PE input sign-extension stage. It accepts 32-bit signed PE results one per cycle and applies an optional rounding right-shift. It narrows (truncates or signed-saturates) each result to the current SEW and packs the narrowed elements into 32-bit words for the register-file write port. It provides valid/ready handshakes on both sides and a sticky saturation flag (vxsat).

Parameters:
W, 32, datapath/word width; only 32 is supported.
SAT_STICKY, 1, 1: vxsat holds until clear_sat; 0: vxsat reflects only the most recently accepted element.

Ports:
clk  in  1  clock
n_reset  in  1  synchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  block can accept an element this cycle
in_data  in  32  signed wide PE result
in_last  in  1  final element of the operation; flushes the partial word
vsew  in  2  output element width: 0=8b, 1=16b, 2/3=32b
shamt  in  5  arithmetic right-shift amount applied before narrowing
round_en  in  1  round-to-nearest-up before shifting
sat_en  in  1  signed saturation enable (0 = truncate)
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts the word
out_data  out  32  packed word; element i occupies bits [i*SEW +: SEW]
out_be  out  4  byte enables of the valid lanes
vxsat  out  1  saturation flag
clear_sat  in  1  clears vxsat

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on n_reset. No async paths.
- Reset values: out_valid=0, out_data=0, out_be=0, vxsat=0, element counter=0, partial word=0. in_ready=1 after reset.
- Reset asserted mid-word or while a word is held: discard all state. No word is emitted.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready; no path from in_valid).
  - out_valid stays high, with out_data/out_be stable, until accepted.
- Elements per word: EPW = 4 (vsew 0), 2 (vsew 1), 1 (vsew 2/3).
- Config sampling: vsew, shamt, round_en and sat_en are sampled with each accepted element. vsew is latched at the first element of a word (counter==0). A vsew change mid-word is ignored until the next word.
- Datapath per element, in 33-bit signed arithmetic:
  - If round_en && shamt!=0: r = in_data + (1 << (shamt-1)); else r = in_data.
  - s = r >>> shamt.
  - Narrow to SEW:
    - sat_en=1: clip s to [-2^(SEW-1), 2^(SEW-1)-1]; a saturation event is raised if clipping occurred.
    - sat_en=0: take the low SEW bits; no event.
    - SEW=32: the result is clipped to the 32-bit range when sat_en=1 (this only matters when the rounding add overflows).
- Packing: the element is written into lane = counter; counter increments.
- Word completes when counter reaches EPW-1 on acceptance, or in_last is accepted.
  - On the next cycle: out_valid=1, out_data = packed word with unused lanes zero, out_be = bytes of filled lanes.
  - Counter returns to 0.
- Latency: one cycle from acceptance of the completing element to out_valid.
- Back-to-back: a new word may start filling in the same cycle the previous word is accepted (in_ready=1 via out_ready). Sustained throughput is one element per cycle.
- Single output register: while out_valid && !out_ready, in_ready=0 and no element is accepted, including partial-word elements. Filling continues only while the output register is free or draining.
- in_last with counter==0 (first element): single-lane word, out_be=0001 for 8b, 0011 for 16b, 1111 for 32b.
- vxsat:
  - SAT_STICKY=1: set on any saturation event and held until clear_sat.
  - SAT_STICKY=0: updated with each accepted element.
  - clear_sat and a saturation event in the same cycle: set wins (vxsat=1).
  - vxsat is registered; it updates the cycle after acceptance.

Test Plan:
- 8b saturating: vsew=0, sat_en=1, shamt=0; inputs 5, -3, 300, -200 (last on the fourth) -> out_data=0x80_7F_FD_05, out_be=1111, vxsat=1 one cycle after the fourth acceptance.
- 16b rounding shift: vsew=1, shamt=4, round_en=1, sat_en=0; inputs 0x18, 0x17 -> lanes 0x0002 and 0x0001, out_data=0x0001_0002, vxsat=0.
- Partial flush: vsew=0; three elements 1, 2, 3 with in_last on the third -> out_data=0x00_03_02_01, out_be=0111, counter=0 afterward.
- Backpressure: hold out_ready=0 after a word completes -> in_ready=0 and out_data stable for 5 cycles. Then out_ready=1 with in_valid=1 -> the word is accepted and a new element is accepted in the same cycle.
- Sticky flag: a saturating element with clear_sat pulsed in the same cycle -> vxsat=1. clear_sat alone on the next cycle -> vxsat=0.
- Reset mid-word: two 8b elements accepted, then n_reset=0 for one cycle -> out_valid=0. The next four elements produce a word containing only those four.
